// File: rtl/freq_gate_counter.sv
// freq_gate_counter: measurement front end of the frequency counter.
// Counts synchronized rising edges of sig_in over back-to-back windows of
// GATE_CYCLES clocks and publishes each completed window's saturating count.

`timescale 1ns/1ps

module freq_gate_counter #(
    parameter int unsigned GATE_CYCLES = 32'd100_000_000,
    parameter int unsigned COUNT_W     = 27
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sig_in,
    input  logic               enable,
    output logic [COUNT_W-1:0] freq_out,
    output logic               valid,
    output logic               overflow
);

    localparam int unsigned        GATE_W    = (GATE_CYCLES > 32'd1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 32'd1);
    localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};

    typedef enum logic {
        IDLE,
        MEASURE
    } state_e;

    state_e state_q, state_d;

    logic sync1_q, sync2_q, sync3_q;
    logic sigEdge, atMax;
    logic measuring, terminal;

    logic [COUNT_W-1:0] edgeCnt_q, edgeCnt_d;
    logic [GATE_W-1:0]  gateCnt_q, gateCnt_d;
    logic               sat_q, sat_d;
    logic [COUNT_W-1:0] freq_q, freq_d;
    logic               overflow_q, overflow_d;
    logic               valid_q, valid_d;

    // Three-flop chain: two stages against metastability, third for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Rising edge of the synchronized input and counter-at-ceiling flag.
    always_comb begin
        sigEdge = sync2_q & ~sync3_q;
        atMax   = (edgeCnt_q == CNT_MAX);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: enable alone decides between measuring and idling.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable)  state_d = MEASURE;
            MEASURE: if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: measuring flag and the last cycle of the gate window.
    always_comb begin
        measuring = (state_q == MEASURE);
        terminal  = measuring && (gateCnt_q == GATE_LAST);
    end

    // Window datapath: count edges, publish on the terminal cycle, restart at once.
    always_comb begin
        edgeCnt_d  = edgeCnt_q;
        gateCnt_d  = gateCnt_q;
        sat_d      = sat_q;
        freq_d     = freq_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        if (!measuring) begin
            edgeCnt_d = '0;
            gateCnt_d = '0;
            sat_d     = 1'b0;
        end else if (terminal) begin
            freq_d     = (sigEdge && !atMax) ? edgeCnt_q + COUNT_W'(1) : edgeCnt_q;
            overflow_d = sat_q | (sigEdge & atMax);
            valid_d    = 1'b1;
            edgeCnt_d  = '0;
            gateCnt_d  = '0;
            sat_d      = 1'b0;
        end else begin
            gateCnt_d = gateCnt_q + GATE_W'(1);
            if (sigEdge) begin
                if (atMax) begin
                    sat_d = 1'b1;
                end else begin
                    edgeCnt_d = edgeCnt_q + COUNT_W'(1);
                end
            end
        end
    end

    // Window datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edgeCnt_q  <= '0;
            gateCnt_q  <= '0;
            sat_q      <= 1'b0;
            freq_q     <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            edgeCnt_q  <= edgeCnt_d;
            gateCnt_q  <= gateCnt_d;
            sat_q      <= sat_d;
            freq_q     <= freq_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign freq_out = freq_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Bench for freq_gate_counter: three instances (wide/100, narrow 4-bit/100,
// wide/1000) share one stimulus; a window-level model predicts every cycle.

`timescale 1ns/1ps

module tb_freq_gate_counter;

    localparam int     NDUT        = 3;
    localparam int     GATES [NDUT] = '{100, 100, 1000};
    localparam longint MAXV  [NDUT] = '{134217727, 15, 134217727};

    logic        clk;
    logic        rst_n;
    logic        sig_in;
    logic        enable;
    logic [26:0] freqA, freqC;
    logic [3:0]  freqB;
    logic        validA, validB, validC;
    logic        ovA, ovB, ovC;

    int total;
    int bad;

    // Stimulus controls for the signal generator
    bit  sigToggle = 1'b0;
    bit  sigLevel  = 1'b0;
    bit  sigJitter = 1'b0;
    real sigHalf   = 50.0;
    real sigPhase  = 1.0;

    // Reference model state
    bit     running  [NDUT];
    int     winPos   [NDUT];
    longint winCnt   [NDUT];
    longint expFreq  [NDUT];
    bit     expOv    [NDUT];
    bit     expValid [NDUT];
    bit     sigHist  [$];

    freq_gate_counter #(.GATE_CYCLES(100), .COUNT_W(27)) dutA (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
        .freq_out(freqA), .valid(validA), .overflow(ovA));

    freq_gate_counter #(.GATE_CYCLES(100), .COUNT_W(4)) dutB (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
        .freq_out(freqB), .valid(validB), .overflow(ovB));

    freq_gate_counter #(.GATE_CYCLES(1000), .COUNT_W(27)) dutC (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
        .freq_out(freqC), .valid(validC), .overflow(ovC));

    // 100 MHz clock, rising edges at 5, 15, 25 ns ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Keeps sig_in transitions clear of the sampling edge so DUT and model agree
    function automatic real nudge(input real t);
        real ph;
        ph = t - 10.0 * $floor(t / 10.0);
        if (ph > 4.5 && ph < 5.5) return t + 1.0;
        return t;
    endfunction

    // Signal generator: held level, or square wave with optional jitter
    initial begin
        real d;
        real tNext;
        sig_in = 1'b0;
        forever begin
            if (!sigToggle) begin
                @(negedge clk);
                if (sigToggle) #(sigPhase);
                else sig_in = sigLevel;
            end else begin
                d = sigHalf;
                if (sigJitter) d = d + (real'(int'($urandom_range(600))) - 300.0) / 1000.0;
                tNext = nudge($realtime + d);
                #(tNext - $realtime);
                if (sigToggle) sig_in = ~sig_in;
            end
        end
    end

    // Window model: a rising transition of the clock-sampled input counts two
    // clocks later; each window is GATE consecutive enabled clocks, result clamped.
    always @(posedge clk) begin : model
        bit seen;
        if (!rst_n) begin
            sigHist = {1'b0, 1'b0, 1'b0, 1'b0};
            for (int i = 0; i < NDUT; i++) begin
                running[i]  = 1'b0;
                winPos[i]   = 0;
                winCnt[i]   = 0;
                expFreq[i]  = 0;
                expOv[i]    = 1'b0;
                expValid[i] = 1'b0;
            end
        end else begin
            sigHist.push_back(sig_in);
            void'(sigHist.pop_front());
            seen = sigHist[1] & ~sigHist[0];
            for (int i = 0; i < NDUT; i++) begin
                expValid[i] = 1'b0;
                if (running[i]) begin
                    winCnt[i] += longint'(seen);
                    winPos[i]++;
                    if (winPos[i] == GATES[i]) begin
                        expFreq[i]  = (winCnt[i] > MAXV[i]) ? MAXV[i] : winCnt[i];
                        expOv[i]    = (winCnt[i] > MAXV[i]);
                        expValid[i] = 1'b1;
                        winPos[i]   = 0;
                        winCnt[i]   = 0;
                    end
                    if (!enable) running[i] = 1'b0;
                end else if (enable) begin
                    running[i] = 1'b1;
                    winPos[i]  = 0;
                    winCnt[i]  = 0;
                end
            end
        end
    end

    // Every cycle, all three instances are compared against the model
    always @(negedge clk) begin : scoreboard
        logic [63:0] obsF [NDUT];
        logic [63:0] obsV [NDUT];
        logic [63:0] obsO [NDUT];
        obsF[0] = 64'(freqA); obsV[0] = 64'(validA); obsO[0] = 64'(ovA);
        obsF[1] = 64'(freqB); obsV[1] = 64'(validB); obsO[1] = 64'(ovB);
        obsF[2] = 64'(freqC); obsV[2] = 64'(validC); obsO[2] = 64'(ovC);
        for (int i = 0; i < NDUT; i++) begin
            checkOutput($sformatf("dut%0d_valid", i), obsV[i], 64'(expValid[i]));
            checkOutput($sformatf("dut%0d_freq", i), obsF[i], 64'(expFreq[i]));
            checkOutput($sformatf("dut%0d_ovf", i), obsO[i], 64'(expOv[i]));
        end
    end

    // Set enable and the signal shape just after a falling edge, then run
    task automatic applyStimulus(input bit en, input bit tog, input bit lvl,
                                 input real half, input bit jit, input int cycles);
        @(negedge clk);
        #2;
        enable    = en;
        sigLevel  = lvl;
        sigHalf   = half;
        sigJitter = jit;
        sigPhase  = 0.5 + real'($urandom_range(35)) / 10.0;
        sigToggle = tog;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_freq", 64'(freqA), 64'd0);
        checkOutput("reset_valid", 64'(validA), 64'd0);
        checkOutput("reset_ovf", 64'(ovA), 64'd0);
        #2 rst_n = 1'b1;

        // Period 10 clocks: ten edges per 100-cycle window
        applyStimulus(1, 1, 0, 50.0, 0, 350);
        checkOutput("t1_freqA", 64'(freqA), 64'd10);
        checkOutput("t1_ovfA", 64'(ovA), 64'd0);
        checkOutput("t1_freqB", 64'(freqB), 64'd10);

        // Input held high from before enabling: no edges in any window
        applyStimulus(0, 0, 1, 50.0, 0, 20);
        applyStimulus(1, 0, 1, 50.0, 0, 250);
        checkOutput("t2_freqA", 64'(freqA), 64'd0);

        // Period 2: fifty edges, clamps the 4-bit instance
        applyStimulus(1, 1, 0, 10.0, 0, 250);
        checkOutput("t3_freqB", 64'(freqB), 64'd15);
        checkOutput("t3_ovfB", 64'(ovB), 64'd1);
        checkOutput("t3_freqA", 64'(freqA), 64'd50);
        checkOutput("t3_ovfA", 64'(ovA), 64'd0);
        // Period 20: five edges, overflow clears
        applyStimulus(1, 1, 0, 100.0, 0, 250);
        checkOutput("t3_slow_freqB", 64'(freqB), 64'd5);
        checkOutput("t3_slow_ovfB", 64'(ovB), 64'd0);

        // Disable mid-window: partial window is discarded
        applyStimulus(0, 1, 0, 50.0, 0, 20);
        applyStimulus(1, 1, 0, 50.0, 0, 101);
        checkOutput("t4_first", 64'(freqA), 64'd10);
        applyStimulus(1, 1, 0, 50.0, 0, 49);
        applyStimulus(0, 1, 0, 50.0, 0, 30);
        checkOutput("t4_held", 64'(freqA), 64'd10);
        applyStimulus(1, 1, 0, 50.0, 0, 101);
        checkOutput("t4_reenable", 64'(freqA), 64'd10);

        // Asynchronous reset between clock edges clears outputs at once
        applyStimulus(1, 1, 0, 50.0, 0, 150);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_freqA", 64'(freqA), 64'd0);
        checkOutput("t5_validA", 64'(validA), 64'd0);
        checkOutput("t5_ovfA", 64'(ovA), 64'd0);
        checkOutput("t5_freqB", 64'(freqB), 64'd0);
        checkOutput("t5_freqC", 64'(freqC), 64'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(1, 1, 0, 50.0, 0, 202);
        checkOutput("t5_after", 64'(freqA), 64'd10);

        // Period 7.3 clocks with jitter over 1000-cycle windows
        applyStimulus(1, 1, 0, 36.5, 1, 2300);
        checkOutput("t6_range", 64'(freqC >= 27'd136 && freqC <= 27'd137), 64'd1);

        // Random segments: enable, signal shape and period all varied
        for (int it = 0; it < 6; it++) begin
            applyStimulus($urandom_range(3) != 0, 1'($urandom_range(1)), 1'($urandom_range(1)),
                          real'($urandom_range(1200, 100)) / 10.0, 1, int'($urandom_range(300, 30)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/freq_gate_counter.md
Name: freq_gate_counter

Overview:
- Measurement front end of the frequency counter.
- Counts rising edges of an asynchronous input signal over a fixed gate window of GATE_CYCLES system clocks.
- Presents the result as an unsigned binary count to the downstream binary-to-BCD converter, which takes a 27-bit value.
- Windows run back-to-back while enabled; each completed window updates the held result and pulses a valid strobe.

Parameters:
- GATE_CYCLES, 100_000_000: gate window length in clk cycles (1 s at 100 MHz); legal range 2 .. 2^32-1.
- COUNT_W, 27: width of the edge counter and result; saturates at 2^COUNT_W-1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sig_in  in  1  measured signal, asynchronous to clk.
- enable  in  1  synchronous run control; high = measure continuously.
- freq_out  out  COUNT_W  edge count of the last completed window; held between windows.
- valid  out  1  one-cycle pulse in the cycle freq_out is updated.
- overflow  out  1  high if the last completed window saturated; updated with freq_out.

Behaviour:
- Reset (rst_n low, asynchronous): sync flops s1, s2, s3 = 0; edge_cnt = 0; gate_cnt = 0; state = IDLE; freq_out = 0; valid = 0; overflow = 0.
- Synchronizer: s1 <= sig_in, s2 <= s1, s3 <= s2, every cycle in all states. edge = s2 & ~s3. A sig_in rising edge is seen as edge 2-3 cycles later.
- State IDLE:
  - edge_cnt and gate_cnt held at 0; valid = 0; freq_out and overflow hold their values.
  - enable sampled high -> MEASURE on the next edge, with gate_cnt = 0.
- State MEASURE:
  - Each cycle, if edge = 1 and edge_cnt < 2^COUNT_W-1, then edge_cnt += 1; at max it holds and the internal sat flag is set.
  - gate_cnt increments each cycle.
  - When gate_cnt == GATE_CYCLES-1 (the terminal cycle):
    - freq_out <= saturating(edge_cnt + edge).
    - overflow <= sat, or saturation occurring on this cycle.
    - valid <= 1 for exactly one cycle.
    - edge_cnt, gate_cnt and sat are cleared.
  - The next window starts immediately, with no dead cycle. Every window samples edge in exactly GATE_CYCLES cycles.
- enable low while in MEASURE: return to IDLE on the next edge. The partial window is discarded: no valid, freq_out unchanged. If enable falls in the terminal cycle, that window still completes and publishes.
- Reset mid-window: immediate clear per the reset values above; no valid.
- Max measurable input frequency is fclk/2; faster inputs alias. This is documented and not detected.
- gate_cnt width is clog2(GATE_CYCLES).
- Output latency: freq_out and valid are registered and become visible the cycle after the terminal cycle.

Test Plan (GATE_CYCLES=100 unless stated):
1. Reset, enable=1, sig_in period 10 clk (5 high/5 low), any phase -> every window freq_out=10, overflow=0, valid pulses exactly every 100 cycles, each pulse 1 cycle wide.
2. sig_in held constant 1 (set high before enable) -> freq_out=0 each window; valid still pulses every 100 cycles.
3. COUNT_W=4, sig_in period 2 clk -> 50 edges saturate: freq_out=15, overflow=1. Then change sig_in to period 20 -> next full window freq_out=5, overflow=0.
4. Window 1 completes with sig_in period 10 (freq_out=10). Then deassert enable at cycle 50 of window 2 -> no valid, freq_out stays 10. Re-enable -> the first new window starts from 0 and reports 10.
5. Assert rst_n low asynchronously mid-window (between clk edges) -> freq_out, valid, overflow go to 0 immediately without a clock. After release, the first window reports a full count (10 for period 10).
6. Asynchronous jitter: sig_in period 7.3 clk with random sub-cycle phase, GATE_CYCLES=1000 -> freq_out within 136..137 for every window; no double counting of a single edge.
